// File: rtl/mux_rr_lib_if.sv
// Bundle of the signals between the producers, the channel mux and its consumer.
// The mux uses the slave view. The producer/consumer side uses the master view.
interface mux_rr_lib_if #(
  parameter int W   = 2,
  parameter int NCH = 4,
  parameter int SW  = $clog2(NCH)
);
  logic [NCH*W-1:0] data_in;
  logic [NCH-1:0]   valid_in;
  logic [SW-1:0]    selector;
  logic             ready_out;
  logic [NCH-1:0]   ack_out;
  logic [W-1:0]     data_out;
  logic             valid_out;
  logic [SW-1:0]    grant_idx;

  modport master (
    output data_in, valid_in, selector, ready_out,
    input  ack_out, data_out, valid_out, grant_idx
  );

  modport slave (
    input  data_in, valid_in, selector, ready_out,
    output ack_out, data_out, valid_out, grant_idx
  );
endinterface

// File: rtl/mux_rr_lib.sv
// Registered N-channel mux. It uses either a fixed select or a round-robin choice among
// the valid channels. A valid/ready output register holds its word during a stall.
module mux_rr_lib #(
  parameter int W    = 2,
  parameter int NCH  = 4,
  parameter int MODE = 1
) (
  input  logic       clk,
  input  logic       reset,
  mux_rr_lib_if.slave bus
);
  localparam int SW   = $clog2(NCH);
  localparam int NSEL = 1 << SW;

  logic [W-1:0]    data_reg;
  logic            valid_reg;
  logic [SW-1:0]   grant_reg;
  logic [SW-1:0]   ptr_reg;
  logic [SW-1:0]   ptr_next;

  logic [W-1:0]    ch_data  [NSEL];
  logic [NSEL-1:0] ch_valid;
  logic [SW-1:0]   rot_idx  [NCH];
  logic [SW-1:0]   cand;
  logic            cand_ok;
  logic            free;
  logic            capture;
  logic [NCH-1:0]  ack;

  // The selector may name an index that has no channel. Those slots read as invalid,
  // so MODE 0 never captures from a channel that does not exist.
  genvar gi;
  generate
    for (gi = 0; gi < NSEL; gi++) begin : g_chan
      if (gi < NCH) begin : g_real
        assign ch_data[gi]  = bus.data_in[gi*W +: W];
        assign ch_valid[gi] = bus.valid_in[gi];
      end else begin : g_pad
        assign ch_data[gi]  = '0;
        assign ch_valid[gi] = 1'b0;
      end
    end
  endgenerate

  // rot_idx[k] is the channel checked k-th in the scan, which is (ptr + k) mod NCH.
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_rot
      logic [SW:0] rot_sum;
      assign rot_sum     = {1'b0, ptr_reg} + (SW+1)'(gi);
      assign rot_idx[gi] = (rot_sum >= (SW+1)'(NCH)) ? SW'(rot_sum - (SW+1)'(NCH))
                                                     : SW'(rot_sum);
    end
  endgenerate

  always_comb begin
    cand    = '0;
    cand_ok = 1'b0;
    if (MODE == 0) begin
      cand    = bus.selector;
      cand_ok = ch_valid[bus.selector];
    end else begin
      // Scan downward so that the lowest scan position (nearest to ptr) wins.
      for (int k = NCH - 1; k >= 0; k--) begin
        if (ch_valid[rot_idx[k]]) begin
          cand    = rot_idx[k];
          cand_ok = 1'b1;
        end
      end
    end
  end

  assign free     = !valid_reg || bus.ready_out;
  assign capture  = free && cand_ok && !reset;
  assign ptr_next = (cand == SW'(NCH - 1)) ? '0 : cand + SW'(1);

  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ack
      assign ack[gi] = capture && (cand == SW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      data_reg  <= '0;
      valid_reg <= 1'b0;
      grant_reg <= '0;
      ptr_reg   <= '0;
    end else if (free) begin
      if (cand_ok) begin
        data_reg  <= ch_data[cand];
        valid_reg <= 1'b1;
        grant_reg <= cand;
        if (MODE != 0) begin
          ptr_reg <= ptr_next;
        end
      end else begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign bus.ack_out   = ack;
  assign bus.data_out  = data_reg;
  assign bus.valid_out = valid_reg;
  assign bus.grant_idx = grant_reg;
endmodule

// File: doc/mux_rr_lib.md
Name: mux_rr_lib

Overview:
- Parametrised, registered N-channel multiplexer for the component library. Successor to the combinational 2x1 muxes (1-bit and 2-bit).
- Generalised in data width, channel count and select mode: fixed external select, or round-robin arbitration among valid channels.
- Output side has a valid/ready handshake with stall hold. Input side returns a per-channel acknowledge.
- Used wherever several producers share one W-bit path.

Parameters:
- W, 2, data width per channel (>=1)
- NCH, 4, number of input channels (>=2; need not be a power of 2)
- MODE, 1, 0 = fixed select via selector input; 1 = round-robin among valid channels
- SW, $clog2(NCH), width of selector and grant_idx (derived; not overridden)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- data_in  input  NCH*W  packed channels; channel i occupies bits [i*W+W-1 : i*W]
- valid_in  input  NCH  channel i has data to offer
- selector  input  SW  channel to pass in MODE 0; ignored in MODE 1
- ready_out  input  1  downstream accepts data_out this cycle
- ack_out  output  NCH  one-hot, combinational; bit i high in the cycle channel i is captured
- data_out  output  W  registered selected data
- valid_out  output  1  registered; data_out holds valid data
- grant_idx  output  SW  registered index of the channel held in data_out

Behaviour:
- Single clock domain. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset effects, applied at that edge regardless of other inputs:
  - data_out=0, valid_out=0, grant_idx=0, round-robin pointer ptr=0.
  - ack_out=0 for as long as reset is high.
  - Any held or stalled word is discarded.
- Register free condition: free = !valid_out | ready_out.
- Stall (!free): data_out, valid_out, grant_idx and ptr all hold; ack_out=0.
- When free, a candidate channel c is chosen combinationally:
  - MODE 0: c = selector. Capture only if selector < NCH and valid_in[selector]=1.
  - MODE 1: c is the first i with valid_in[i]=1, scanning ptr, ptr+1, ..., NCH-1, 0, ..., ptr-1 (ptr checked first, wrap modulo NCH).
- Capture (free and candidate exists), at the clock edge:
  - data_out <= data_in[c]; valid_out <= 1; grant_idx <= c.
  - ack_out[c]=1 during that cycle.
  - MODE 1 only: ptr <= (c==NCH-1) ? 0 : c+1.
- No capture while free (no valid candidate, or MODE 0 selector out of range):
  - valid_out <= 0.
  - data_out, grant_idx and ptr hold their values.
  - ack_out=0.
- Latency: one cycle from ack_out[c] to valid_out/data_out. Back-to-back captures are allowed every cycle while ready_out=1 (full throughput).
- Simultaneous ready_out=1 and new capture: the old word is consumed and the new word is loaded at the same edge. No bubble.
- In MODE 0, ptr stays at its reset value (0) and does not affect behaviour.
- ack_out is at most one-hot. It never asserts while reset=1 or during a stall.
- valid_in is not required to stay high once raised. An un-acked channel may drop valid_in without error.
- No combinational path from ready_out to data_out. ack_out does depend combinationally on ready_out, valid_in and selector.

Test Plan:
- Reset: W=2, NCH=4, MODE=1, valid_in=4'b1111, reset high 2 cycles -> valid_out=0, data_out=2'b00, grant_idx=0, ack_out=0 throughout.
- Round-robin full load: data_in={2'b11,2'b10,2'b01,2'b00}, valid_in=4'b1111, ready_out=1 after reset -> consecutive cycles grant_idx 0,1,2,3,0 and data_out 00,01,10,11,00; ack_out 0001,0010,0100,1000,0001.
- Stall: with valid_out=1, data_out=01, grant_idx=1, drop ready_out for 3 cycles -> outputs and ptr frozen, ack_out=0. Raise ready_out -> next capture is channel 2 (data 10).
- Sparse round-robin: valid_in=4'b1001, ptr=1 -> grants 3,0,3,0. valid_in=0 -> valid_out=0 next cycle, data_out holds last value.
- MODE 0: selector=2, valid_in=4'b1011 -> valid_out=0. Set valid_in[2]=1 -> captures channel 2 every cycle with ack_out=0100. selector=3'd... out of range is impossible at NCH=4; on an NCH=3 instance, selector=3 -> valid_out=0, ack_out=0.
- NCH=3, MODE=1, W=4: all valid -> grants 0,1,2,0 (wrap 2->0). Assert reset during a stall holding 4'hA -> next cycle valid_out=0, data_out=0, and the first grant after release is channel 0.
